// File: rtl/seq_bin_to_bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encodings and the double-dabble digit adjustment constants.
package seq_bin_to_bcd_pkg;

    localparam int unsigned DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;
    localparam logic [DIGIT_W-1:0] ADJ_ADD    = 4'd3;

    // Encoding 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage : seq_bin_to_bcd_pkg

// File: rtl/seq_bin_to_bcd_digit_adjust.sv
// Combinational double-dabble cell: adds 3 to a BCD digit of 5 or more
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adjust
    import seq_bin_to_bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_in,
    output logic [DIGIT_W-1:0] digit_out
);

    // Add-3 correction; 5..9 map to 8..12, which never wraps in 4 bits.
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= ADJ_THRESH) begin
            digit_out = digit_in + ADJ_ADD;
        end else begin
            digit_out = digit_in;
        end
    end

endmodule : bcd_digit_adjust

// File: rtl/seq_bin_to_bcd.sv
// Sequential double-dabble converter: one input bit per clock, start/busy/done
// handshake, with bcd/overflow registered and updated only on completion.
module seq_bin_to_bcd
    import seq_bin_to_bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [BIN_W-1:0]            bin,
    output logic                        busy,
    output logic                        done,
    output logic [DIGIT_W*DIGITS-1:0]   bcd,
    output logic                        overflow
);

    localparam int unsigned BCD_W = DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   work_q, work_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               overflow_q, overflow_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [BCD_W-1:0]   adj_s;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_in  (work_q[g*DIGIT_W +: DIGIT_W]),
            .digit_out (adj_s[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Next-state, shift datapath and output-register update logic.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        work_d     = work_q;
        ovf_acc_d  = ovf_acc_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = bin;
                    work_d    = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end else begin
                    state_d   = IDLE;
                end
            end
            SHIFT: begin
                {work_d, shift_d} = {adj_s[BCD_W-2:0], shift_q, 1'b0};
                ovf_acc_d = ovf_acc_q | adj_s[BCD_W-1];
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                bcd_d      = work_q;
                overflow_d = ovf_acc_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            work_q     <= '0;
            ovf_acc_q  <= 1'b0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            work_q     <= work_d;
            ovf_acc_q  <= ovf_acc_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = overflow_q;

endmodule : seq_bin_to_bcd

// File: tb/tb_seq_bin_to_bcd.sv
// Self-checking bench for seq_bin_to_bcd: directed cases plus random values
// compared against a decimal-arithmetic reference, on 5-digit and 4-digit instances.
module tb_seq_bin_to_bcd;

    logic        clk = 1'b0;
    logic        reset;
    logic        start5, start4;
    logic [15:0] bin;
    logic        busy5, done5, ovf5;
    logic [19:0] bcd5;
    logic        busy4, done4, ovf4;
    logic [15:0] bcd4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_bin_to_bcd #(.BIN_W(16), .DIGITS(5)) dut5 (
        .clk(clk), .reset(reset), .start(start5), .bin(bin),
        .busy(busy5), .done(done5), .bcd(bcd5), .overflow(ovf5)
    );

    seq_bin_to_bcd #(.BIN_W(16), .DIGITS(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .bin(bin),
        .busy(busy4), .done(done4), .bcd(bcd4), .overflow(ovf4)
    );

    function automatic logic [31:0] model_bcd(input int unsigned v, input int unsigned d);
        logic [31:0] r = 32'd0;
        int unsigned x = v;
        for (int i = 0; i < d; i++) begin
            r = r | ((x % 10) << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic model_ovf(input int unsigned v, input int unsigned d);
        return (v >= (10 ** d)) ? 1'b1 : 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start one conversion on the selected instance and check latency, busy
    // duration, result and the single-cycle done pulse.
    task automatic conv(input logic [15:0] v, input bit sel, input bit glitch);
        int k = 0;
        int busy_cnt = 0;
        bit seen = 1'b0;
        int unsigned d = sel ? 4 : 5;
        bin = v;
        if (sel) start4 = 1'b1; else start5 = 1'b1;
        step();
        start4 = 1'b0;
        start5 = 1'b0;
        while (!seen && k < 40) begin
            if (sel ? busy4 : busy5) busy_cnt++;
            if (glitch && k == 3) begin bin = 16'd9999; start5 = 1'b1; end
            if (glitch && k == 5) start5 = 1'b0;
            step();
            k++;
            if (sel ? done4 : done5) seen = 1'b1;
        end
        check("latency", 32'(k), 32'd17);
        check("busy_len", 32'(busy_cnt), 32'd17);
        check("bcd", sel ? {16'd0, bcd4} : {12'd0, bcd5}, model_bcd(32'(v), d));
        check("ovf", {31'd0, sel ? ovf4 : ovf5}, {31'd0, model_ovf(32'(v), d)});
        step();
        check("done_single", {31'd0, sel ? done4 : done5}, 32'd0);
    endtask

    initial begin
        int k;
        logic [15:0] rv;
        reset  = 1'b1;
        start5 = 1'b0;
        start4 = 1'b0;
        bin    = 16'd0;
        #1;
        check("rst_busy", {31'd0, busy5}, 32'd0);
        check("rst_done", {31'd0, done5}, 32'd0);
        check("rst_bcd", {12'd0, bcd5}, 32'd0);
        check("rst_ovf", {31'd0, ovf5}, 32'd0);
        check("rst_bcd4", {16'd0, bcd4}, 32'd0);
        step();
        step();
        reset = 1'b0;
        step();

        conv(16'd0, 1'b0, 1'b0);
        conv(16'd65535, 1'b0, 1'b0);
        conv(16'd1234, 1'b0, 1'b1);
        k = 0;
        repeat (25) begin
            step();
            if (done5) k++;
        end
        check("no_extra_done", 32'(k), 32'd0);
        check("bcd_held", {12'd0, bcd5}, 32'h01234);

        // Asynchronous reset in the middle of a conversion.
        bin = 16'd4321;
        start5 = 1'b1;
        step();
        start5 = 1'b0;
        repeat (8) step();
        #2 reset = 1'b1;
        #1;
        check("mid_rst_bcd", {12'd0, bcd5}, 32'd0);
        check("mid_rst_busy", {31'd0, busy5}, 32'd0);
        check("mid_rst_done", {31'd0, done5}, 32'd0);
        #2 reset = 1'b0;
        step();
        conv(16'd42, 1'b0, 1'b0);

        // Back-to-back with start held high.
        bin = 16'd100;
        start5 = 1'b1;
        step();
        bin = 16'd255;
        k = 0;
        while (!done5 && k < 40) begin step(); k++; end
        check("b2b_first_lat", 32'(k), 32'd17);
        check("b2b_first_bcd", {12'd0, bcd5}, 32'h00100);
        step();
        k++;
        start5 = 1'b0;
        while (!done5 && k < 80) begin step(); k++; end
        check("b2b_gap", 32'(k), 32'd35);
        check("b2b_second_bcd", {12'd0, bcd5}, 32'h00255);
        step();

        conv(16'd12345, 1'b1, 1'b0);
        conv(16'd9999, 1'b1, 1'b0);

        for (int i = 0; i < 12; i++) begin
            rv = 16'($urandom_range(65535, 0));
            conv(rv, 1'b0, 1'b0);
            rv = 16'($urandom_range(65535, 0));
            conv(rv, 1'b1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_seq_bin_to_bcd
